// File: rtl/divider_with_buffer.sv
// Buffered unsigned restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Optional operand readback on opnd_out is enabled by defining DIVIDER_READBACK_EN.
module divider_with_buffer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   din,
    input  logic [1:0]     sel,
    input  logic           load,
    input  logic           start,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz,
    output logic [N-1:0]   opnd_out,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(2*N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: load and start are level inputs sampled on every rising edge;
    // both are ignored in RUN, and load wins when both are high on the same edge.

    state_t         state_q, state_d;
    logic [2*N-1:0] a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] a_w_q, a_w_d;
    logic [N-1:0]   b_w_q, b_w_d;
    logic [N-1:0]   rem_w_q, rem_w_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;

    logic           idle_or_done;
    logic           start_ok;
    logic [N:0]     partial;
    logic           ge;
    logic [N-1:0]   rem_step;
    logic [2*N-1:0] q_step;

    assign idle_or_done = (state_q != S_RUN);
    assign start_ok     = idle_or_done && !load && start;

    // The working dividend shifts left each step and collects quotient bits in its LSBs.
    assign partial  = {rem_w_q, a_w_q[2*N-1]};
    assign ge       = (partial >= {1'b0, b_w_q});
    assign rem_step = ge ? (partial[N-1:0] - b_w_q) : partial[N-1:0];
    assign q_step   = {a_w_q[2*N-2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = (b_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        a_w_d       = a_w_q;
        b_w_d       = b_w_q;
        rem_w_d     = rem_w_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (idle_or_done && load) begin
            case (sel)
                2'd0:    a_d[N-1:0]   = din;
                2'd1:    a_d[2*N-1:N] = din;
                2'd2:    b_d          = din;
                default: ;
            endcase
            dbz_d = 1'b0;
        end

        if (start_ok) begin
            if (b_q != '0) begin
                a_w_d   = a_q;
                b_w_d   = b_q;
                rem_w_d = '0;
                cnt_d   = CW'(2*N-1);
                dbz_d   = 1'b0;
            end else begin
                dbz_d       = 1'b1;
                quotient_d  = '1;
                remainder_d = a_q[N-1:0];
            end
        end

        if (state_q == S_RUN) begin
            a_w_d   = q_step;
            rem_w_d = rem_step;
            if (cnt_q == '0) begin
                quotient_d  = q_step;
                remainder_d = rem_step;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            a_w_q       <= '0;
            b_w_q       <= '0;
            rem_w_q     <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            a_w_q       <= a_w_d;
            b_w_q       <= b_w_d;
            rem_w_q     <= rem_w_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

`ifdef DIVIDER_READBACK_EN
    logic [N-1:0] opnd_q, opnd_d;

    always_comb begin
        opnd_d = '0;
        case (sel)
            2'd0:    opnd_d = a_q[N-1:0];
            2'd1:    opnd_d = a_q[2*N-1:N];
            2'd2:    opnd_d = b_q;
            default: opnd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_q <= '0;
        end else begin
            opnd_q <= opnd_d;
        end
    end

    assign opnd_out = opnd_q;
`else
    assign opnd_out = '0;
`endif

endmodule

// File: tb/tb_divider_with_buffer.sv
// Self-checking bench for divider_with_buffer: directed cases, corner cases and random
// operands checked against a plain-arithmetic reference model.
module tb_divider_with_buffer;
  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   din;
  logic [1:0]     sel;
  logic           load;
  logic           start;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           dbz;
  logic [N-1:0]   opnd_out;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3*N-1:0] exp_q[$];

  divider_with_buffer #(.N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .load(load), .start(start),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .dbz(dbz), .opnd_out(opnd_out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: {quotient, remainder}
  function automatic logic [3*N-1:0] model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] q;
    logic [2*N-1:0] r;
    if (b == 0) begin
      q = '1;
      r = {{N{1'b0}}, a[N-1:0]};
    end else begin
      q = a / {{N{1'b0}}, b};
      r = a % {{N{1'b0}}, b};
    end
    return {q, r[N-1:0]};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [1:0] s, input logic [N-1:0] v);
    load = 1'b1;
    sel  = s;
    din  = v;
    tick();
    load = 1'b0;
    sel  = 2'd3;
  endtask

  task automatic load_ab(input logic [2*N-1:0] a, input logic [N-1:0] b);
    load_op(2'd0, a[N-1:0]);
    load_op(2'd1, a[2*N-1:N]);
    load_op(2'd2, b);
  endtask

  // Starts a division of the buffered operands (a, b) and checks timing and result.
  // poke_start / poke_b: RUN cycle index at which to pulse start / load a new B (-1 = never).
  task automatic run_div(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input int poke_start, input int poke_b,
                         input logic [N-1:0] poke_val, input string name);
    int cnt;
    int exp_cycles;
    logic [3*N-1:0] exp;
    exp_q.push_back(model(a, b));
    exp_cycles = (b == 0) ? 0 : 2 * N;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b want 1", name, cnt, busy);
      end
      if (cnt == poke_start) start = 1'b1;
      if (cnt == poke_b) begin
        load = 1'b1;
        sel  = 2'd2;
        din  = poke_val;
      end
      tick();
      start = 1'b0;
      load  = 1'b0;
      sel   = 2'd3;
      cnt++;
    end
    checks++;
    if (cnt !== exp_cycles) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, cnt, exp_cycles);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done got %b want 0", name, busy);
    end
    checks++;
    if (dbz !== (b == 0)) begin
      errors++;
      $display("FAIL %s dbz got %b want %b", name, dbz, (b == 0));
    end
    exp = exp_q.pop_front();
    checks++;
    if ({quotient, remainder} !== exp) begin
      errors++;
      $display("FAIL %s result got q=%h r=%h want q=%h r=%h", name, quotient, remainder,
               exp[3*N-1:N], exp[N-1:0]);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({quotient, remainder, busy, done, dbz, opnd_out} !== '0) begin
      errors++;
      $display("FAIL reset outputs q=%h r=%h busy=%b done=%b dbz=%b opnd=%h want all 0",
               quotient, remainder, busy, done, dbz, opnd_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    load_ab(16'h1234, 8'h10);
    run_div(16'h1234, 8'h10, -1, -1, 8'h00, "div_1234_10");
    load_ab(16'hFFFF, 8'hFF);
    run_div(16'hFFFF, 8'hFF, 5, -1, 8'h00, "div_ffff_ff_start_in_run");
    load_ab(16'h0005, 8'h07);
    run_div(16'h0005, 8'h07, -1, -1, 8'h00, "div_0005_07");
    load_ab(16'hABCD, 8'h00);
    run_div(16'hABCD, 8'h00, -1, -1, 8'h00, "div_by_zero");
  endtask

  task automatic test_load_in_done();
    load_op(2'd0, 8'h11);
    checks++;
    if (done !== 1'b0 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL load_in_done flags got done=%b dbz=%b want 0 0", done, dbz);
    end
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 8'hCD) begin
      errors++;
      $display("FAIL load_in_done hold got q=%h r=%h want q=ffff r=cd", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    load_ab(16'h0100, 8'h03);
    run_div(16'h0100, 8'h03, -1, -1, 8'h00, "b2b_first");
    run_div(16'h0100, 8'h03, -1, -1, 8'h00, "b2b_start_in_done");
  endtask

  task automatic test_load_start_same();
    load  = 1'b1;
    start = 1'b1;
    sel   = 2'd3;
    tick();
    load  = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_start_same got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_in_run();
    load_ab(16'h1234, 8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_run pre busy got %b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, dbz, opnd_out} !== '0) begin
      errors++;
      $display("FAIL reset_in_run outputs q=%h r=%h busy=%b done=%b dbz=%b opnd=%h want all 0",
               quotient, remainder, busy, done, dbz, opnd_out);
    end
    tick();
    rst = 1'b0;
    tick();
    load_ab(16'h1234, 8'h10);
    run_div(16'h1234, 8'h10, -1, -1, 8'h00, "rerun_after_reset");
  endtask

  task automatic test_load_during_run();
    logic [N-1:0] exp_rb;
    load_ab(16'h9876, 8'h21);
    run_div(16'h9876, 8'h21, -1, 3, 8'h05, "load_b_in_run");
    sel = 2'd2;
    tick();
`ifdef DIVIDER_READBACK_EN
    exp_rb = 8'h21;
`else
    exp_rb = 8'h00;
`endif
    checks++;
    if (opnd_out !== exp_rb) begin
      errors++;
      $display("FAIL readback_b got %h want %h", opnd_out, exp_rb);
    end
    sel = 2'd1;
    tick();
`ifdef DIVIDER_READBACK_EN
    exp_rb = 8'h98;
`else
    exp_rb = 8'h00;
`endif
    checks++;
    if (opnd_out !== exp_rb) begin
      errors++;
      $display("FAIL readback_a_hi got %h want %h", opnd_out, exp_rb);
    end
    sel = 2'd3;
  endtask

  task automatic test_random();
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, 65535));
      if (i % 6 == 0)      b = 8'h00;
      else if (i % 4 == 0) b = 8'($urandom_range(1, 4));
      else                 b = 8'($urandom_range(1, 255));
      load_ab(a, b);
      run_div(a, b, (i % 3 == 0) ? 7 : -1, (i % 5 == 1) ? 2 : -1,
              8'($urandom_range(0, 255)), "random");
    end
  endtask

  initial begin
    rst   = 1'b1;
    din   = '0;
    sel   = 2'd3;
    load  = 1'b0;
    start = 1'b0;
    test_reset();
    test_directed();
    test_load_in_done();
    test_back_to_back();
    test_load_start_same();
    test_reset_in_run();
    test_load_during_run();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
